wrr_arb: RTL and testbench
==========================

Name: wrr_arb

Overview:
- Weighted round-robin arbiter with optional packet lock; next generation of the single-beat round-robin arbiter.
- Each requestor may win up to a programmable number of consecutive packets before priority rotates.
- With lock enabled, the grant is held on one requestor from the first accepted beat of a packet until its last beat.
- Sits in front of shared resources such as output ports, memory banks or shared pipes; grant is combinational from request and registered state.

Parameters:
- W, 4, number of requestors (>= 2).
- WEIGHT_W, 4, width of each per-requestor weight field and of the credit counter.

Ports:
- clk  input  1  clock.
- srst  input  1  synchronous active-high reset.
- i_req  input  W  per-requestor request.
- i_weight  input  W*WEIGHT_W  per-requestor packet quota; field k = bits [k*WEIGHT_W +: WEIGHT_W].
- i_ack  input  1  downstream accepts the current granted beat.
- i_last  input  1  accepted beat is last of its packet; ignored unless lock is compiled in.
- o_gnt  output  W  one-hot grant.
- o_gnt_vld  output  1  grant is valid, i.e. the granted requestor's i_req is high.
- o_gnt_enc  output  $clog2(W)  binary index of o_gnt.

Behaviour:
- State registers:
  - ptr: $clog2(W) bits, search start, inclusive.
  - cnt: WEIGHT_W bits, packets already won consecutively by index ptr.
  - locked: 1 bit.
  - owner: $clog2(W) bits.
- Reset: srst high on a clock edge sets ptr=0, cnt=0, locked=0, owner=0. While srst is high, o_gnt='0, o_gnt_vld=0, o_gnt_enc=0.
- Unlocked arbitration:
  - Grant goes to the first set bit of i_req scanning upward from ptr inclusive, wrapping W-1 -> 0.
  - o_gnt_vld = |i_req.
  - If i_req == 0: o_gnt='0, o_gnt_enc=0, vld=0.
- Beat accepted: i_ack && o_gnt_vld. i_ack while vld=0 is ignored and changes no state.
- Packet completion: an accepted beat with last=1. last = i_last with lock compiled in, 1 without.
- Credit update on completion for granted index g:
  - Effective weight ew = (i_weight[g] == 0) ? 1 : i_weight[g], sampled in the completion cycle.
  - cnt_n = (g == ptr) ? cnt + 1 : 1.
  - If cnt_n >= ew: ptr <= (g + 1) mod W, cnt <= 0.
  - Else: ptr <= g, cnt <= cnt_n.
  - Counter arithmetic is WEIGHT_W+1 bits wide internally; no wrap is possible since cnt < ew <= 2^WEIGHT_W - 1.
- Lock state machine (lock compiled in), two states:
  - UNLOCKED -> LOCKED on an accepted beat with i_last=0; owner <= g.
  - LOCKED: o_gnt = onehot(owner), o_gnt_enc = owner, o_gnt_vld = i_req[owner]. Other requests are ignored.
  - LOCKED -> UNLOCKED on an accepted beat with i_last=1; credit update applies with g = owner.
  - LOCKED, accepted beat with i_last=0: stay LOCKED, no credit change.
  - Single-beat packet (accepted with i_last=1 while UNLOCKED): stay UNLOCKED, credit update only.
  - Owner drops i_req while LOCKED: grant stays on owner with vld=0 (bubble); no re-arbitration until owner's last beat.
- Latency: grant is combinational (0 cycles) from i_req and state. State changes take effect in the cycle after the accept.
- Weight changes take effect at the next completion; a weight lowered below the current cnt causes rotation at the next completion.
- Non-power-of-2 W: ptr wraps from W-1 to 0; encoded values >= W never occur.

Optional Feature:
- Macro: H_WRR_ARB_LOCK_EN.
- Defined: packet lock as described above; i_last is honoured.
- Undefined: every accepted beat is a completed packet; the locked and owner registers are not implemented; i_last is unused; arbitration is re-evaluated every cycle.

Test Plan:
- (W=4, weights all 1, lock on) reset, i_req=4'b1111, i_ack=1, i_last=1 every cycle -> o_gnt 0001, 0010, 0100, 1000, 0001.
- weight[0]=2, others 1, i_req=1111, ack/last=1 every cycle -> 0001, 0001, 0010, 0100, 1000, 0001, 0001.
- i_req=0011, weights 1, ack every cycle, i_last on every 3rd beat -> 0001 x3 then 0010 x3; locked=1 during beats 1-2 of each packet.
- Owner 0 locked after one beat, i_req drops to 0010 for 2 cycles with ack=1 -> o_gnt=0001, vld=0, state unchanged; i_req=0011 with last -> next grant 0010.
- Only i_req[2] set, weight[2]=0 -> grant 0100 every cycle, ptr=3 after each completion, cnt stays 0.
- srst asserted for one cycle while locked on owner 3 -> next cycle ptr=0, unlocked; i_req=1010 -> o_gnt=0010, o_gnt_enc=1.

Source files
------------

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: each requestor may win up to its weight in
// consecutive packets before priority rotates. Optional packet lock: H_WRR_ARB_LOCK_EN.
module wrr_arb #(
   parameter int unsigned W        = 4,
   parameter int unsigned WEIGHT_W = 4
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [W-1:0]          i_req,
   input  logic [W*WEIGHT_W-1:0] i_weight,
   input  logic                  i_ack,
   input  logic                  i_last,
   output logic [W-1:0]          o_gnt,
   output logic                  o_gnt_vld,
   output logic [$clog2(W)-1:0]  o_gnt_enc
);
   localparam int unsigned PW = $clog2(W);
   localparam int unsigned CW = WEIGHT_W + 1;

   logic [PW-1:0]       ptr_q, ptr_d;
   logic [WEIGHT_W-1:0] cnt_q, cnt_d;

   logic                scan_hit_c;
   logic [PW-1:0]       scan_idx_c;
   int unsigned         scan_pos;
   logic [W-1:0]        gnt_c;
   logic                vld_c;
   logic [PW-1:0]       enc_c;
   logic                accept_c;
   logic                done_c;
   logic [WEIGHT_W-1:0] weight_a [W];
   logic [WEIGHT_W-1:0] wt_sel_c;
   logic [CW-1:0]       ew_c;
   logic [CW-1:0]       cnt_n_c;

`ifdef H_WRR_ARB_LOCK_EN
   typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;
   state_e        state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
`endif

   for (genvar gi = 0; gi < W; gi++) begin : g_wt
      assign weight_a[gi] = i_weight[gi*WEIGHT_W +: WEIGHT_W];
   end

   // First requestor at or above ptr, wrapping at W-1
   always_comb begin
      scan_hit_c = 1'b0;
      scan_idx_c = '0;
      scan_pos   = 0;
      for (int unsigned k = 0; k < W; k++) begin
         scan_pos = 32'(ptr_q) + k;
         if (scan_pos >= W) scan_pos = scan_pos - W;
         if (!scan_hit_c && i_req[PW'(scan_pos)]) begin
            scan_hit_c = 1'b1;
            scan_idx_c = PW'(scan_pos);
         end
      end
   end

   always_comb begin
      gnt_c = '0;
      vld_c = 1'b0;
      enc_c = '0;
      if (srst) begin
         gnt_c = '0;
      end
`ifdef H_WRR_ARB_LOCK_EN
      else if (state_q == ST_LOCKED) begin
         gnt_c[owner_q] = 1'b1;
         enc_c          = owner_q;
         vld_c          = i_req[owner_q];
      end
`endif
      else if (scan_hit_c) begin
         gnt_c[scan_idx_c] = 1'b1;
         enc_c             = scan_idx_c;
         vld_c             = 1'b1;
      end
   end

   assign o_gnt     = gnt_c;
   assign o_gnt_vld = vld_c;
   assign o_gnt_enc = enc_c;

   assign accept_c = i_ack & vld_c;
`ifdef H_WRR_ARB_LOCK_EN
   assign done_c = accept_c & i_last;
`else
   assign done_c = accept_c;
   logic unused_last;
   assign unused_last = i_last;
`endif

   // A zero weight still grants one packet per turn
   assign wt_sel_c = weight_a[enc_c];
   assign ew_c     = (wt_sel_c == '0) ? CW'(1) : CW'(wt_sel_c);
   assign cnt_n_c  = (enc_c == ptr_q) ? CW'(cnt_q) + CW'(1) : CW'(1);

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (done_c) begin
         if (cnt_n_c >= ew_c) begin
            ptr_d = (enc_c == PW'(W-1)) ? '0 : enc_c + PW'(1);
            cnt_d = '0;
         end else begin
            ptr_d = enc_c;
            cnt_d = cnt_n_c[WEIGHT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef H_WRR_ARB_LOCK_EN
   // Hold the grant on the owner from its first accepted beat to its last
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (accept_c && !i_last) begin
               state_d = ST_LOCKED;
               owner_d = enc_c;
            end
         end
         ST_LOCKED: begin
            if (accept_c && i_last) state_d = ST_UNLOCKED;
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_UNLOCKED;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end
`endif

endmodule

// File: tb/tb_wrr_arb.sv
// Bench for wrr_arb: directed vector table, lock corner sequences and a
// randomized run against a rule-level reference model.
module tb_wrr_arb;
   localparam int unsigned W        = 4;
   localparam int unsigned WEIGHT_W = 4;
   localparam int unsigned PW       = 2;
`ifdef H_WRR_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  srst;
   logic [W-1:0]          i_req;
   logic [W*WEIGHT_W-1:0] i_weight;
   logic                  i_ack;
   logic                  i_last;
   logic [W-1:0]          o_gnt;
   logic                  o_gnt_vld;
   logic [PW-1:0]         o_gnt_enc;

   always #5 clk = ~clk;

   wrr_arb #(.W(W), .WEIGHT_W(WEIGHT_W)) dut (
      .clk       (clk),
      .srst      (srst),
      .i_req     (i_req),
      .i_weight  (i_weight),
      .i_ack     (i_ack),
      .i_last    (i_last),
      .o_gnt     (o_gnt),
      .o_gnt_vld (o_gnt_vld),
      .o_gnt_enc (o_gnt_enc)
   );

   typedef struct {
      logic                  rst;
      logic [W-1:0]          req;
      logic [W*WEIGHT_W-1:0] wt;
      logic                  ack;
      logic                  last;
      logic [W-1:0]          gnt;
      logic                  vld;
      logic [PW-1:0]         enc;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: rotation start, packets won in a row, lock holder
   int m_ptr    = 0;
   int m_cnt    = 0;
   int m_owner  = 0;
   bit m_locked = 1'b0;

   function automatic vec_t mk(input logic rst, input logic [W-1:0] req,
                               input logic [W*WEIGHT_W-1:0] wt, input logic ack,
                               input logic last, input logic [W-1:0] gnt,
                               input logic vld, input logic [PW-1:0] enc);
      vec_t v;
      v.rst = rst; v.req = req; v.wt = wt; v.ack = ack; v.last = last;
      v.gnt = gnt; v.vld = vld; v.enc = enc;
      return v;
   endfunction

   function automatic void model_out(input logic rst, input logic [W-1:0] req,
                                     output logic [W-1:0] g, output logic v,
                                     output logic [PW-1:0] e);
      g = '0;
      v = 1'b0;
      e = '0;
      if (rst) return;
      if (m_locked) begin
         g[PW'(m_owner)] = 1'b1;
         e = PW'(m_owner);
         v = req[PW'(m_owner)];
         return;
      end
      for (int k = 0; k < int'(W); k++) begin
         if (req[PW'((m_ptr + k) % int'(W))]) begin
            g[PW'((m_ptr + k) % int'(W))] = 1'b1;
            e = PW'((m_ptr + k) % int'(W));
            v = 1'b1;
            return;
         end
      end
   endfunction

   function automatic void model_step(input logic rst, input logic [W-1:0] req,
                                      input logic [W*WEIGHT_W-1:0] wt,
                                      input logic ack, input logic last);
      logic [W-1:0]  g;
      logic          v;
      logic [PW-1:0] e;
      int            gi;
      int            ew;
      int            cn;
      bit            lastb;
      if (rst) begin
         m_ptr = 0; m_cnt = 0; m_locked = 1'b0; m_owner = 0;
         return;
      end
      model_out(1'b0, req, g, v, e);
      if (!(v && ack)) return;
      gi    = int'(e);
      lastb = LOCK ? last : 1'b1;
      if (!lastb) begin
         if (!m_locked) begin
            m_locked = 1'b1;
            m_owner  = gi;
         end
         return;
      end
      m_locked = 1'b0;
      ew = int'(wt[gi*WEIGHT_W +: WEIGHT_W]);
      if (ew == 0) ew = 1;
      cn = (gi == m_ptr) ? m_cnt + 1 : 1;
      if (cn >= ew) begin
         m_ptr = (gi + 1) % int'(W);
         m_cnt = 0;
      end else begin
         m_ptr = gi;
         m_cnt = cn;
      end
   endfunction

   task automatic step(input vec_t v, input string name);
      srst     = v.rst;
      i_req    = v.req;
      i_weight = v.wt;
      i_ack    = v.ack;
      i_last   = v.last;
      @(negedge clk);
      n_vec++;
      if (o_gnt !== v.gnt || o_gnt_vld !== v.vld || o_gnt_enc !== v.enc) begin
         n_err++;
         $display("FAIL %s @%0t: got gnt=%b vld=%b enc=%0d, want gnt=%b vld=%b enc=%0d",
                  name, $time, o_gnt, o_gnt_vld, o_gnt_enc, v.gnt, v.vld, v.enc);
      end
      model_step(v.rst, v.req, v.wt, v.ack, v.last);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      logic [W-1:0]          rq;
      logic [W*WEIGHT_W-1:0] rw;
      logic                  rr;
      logic                  ra;
      logic                  rl;
      logic [W-1:0]          eg;
      logic                  ev;
      logic [PW-1:0]         ee;

      srst = 1'b1; i_req = '0; i_weight = '0; i_ack = 1'b0; i_last = 1'b0;
      @(posedge clk);
      #1;

      // reset, plain rotation
      tbl.push_back(mk(1, 4'b1111, 16'h1111, 1, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 1, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 1, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 1, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 1, 1, 4'b1000, 1, 3));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 1, 1, 4'b0001, 1, 0));
      // weight[0]=2
      tbl.push_back(mk(1, 4'b1111, 16'h1112, 1, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0010, 1, 1));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b1000, 1, 3));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 1, 1, 4'b0001, 1, 0));
      // ack without request is ignored; wrap search from ptr=1
      tbl.push_back(mk(0, 4'b0000, 16'h1112, 1, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0001, 16'h1112, 0, 1, 4'b0001, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 16'h1112, 1, 0, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 16'h1112, 0, 1, 4'b0010, 1, 1));
      // zero weight on requestor 2
      tbl.push_back(mk(1, 4'b0100, 16'h1011, 1, 1, 4'b0000, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 16'h1011, 1, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b0100, 16'h1011, 1, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b0100, 16'h1011, 1, 1, 4'b0100, 1, 2));
      tbl.push_back(mk(0, 4'b1100, 16'h1011, 0, 1, 4'b1000, 1, 3));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("table[%0d]", i));

      // reset while the grant sits on requestor 3
      step(mk(1, 4'b0000, 16'h1111, 0, 0, 4'b0000, 0, 0), "rst_owner3_pre");
      step(mk(0, 4'b1000, 16'h1111, 1, 0, 4'b1000, 1, 3), "rst_owner3_lock");
      step(mk(1, 4'b1010, 16'h1111, 1, 1, 4'b0000, 0, 0), "rst_owner3_srst");
      step(mk(0, 4'b1010, 16'h1111, 1, 1, 4'b0010, 1, 1), "rst_owner3_after");
      step(mk(0, 4'b1010, 16'h1111, 0, 0, 4'b1000, 1, 3), "rst_owner3_next");

`ifdef H_WRR_ARB_LOCK_EN
      // three-beat packets from two requestors
      step(mk(1, 4'b0000, 16'h1111, 0, 0, 4'b0000, 0, 0), "pkt3_rst");
      for (int b = 0; b < 6; b++)
         step(mk(0, 4'b0011, 16'h1111, 1, logic'(b % 3 == 2),
                 (b < 3) ? 4'b0001 : 4'b0010, 1, (b < 3) ? 2'd0 : 2'd1),
              $sformatf("pkt3_beat%0d", b));
      // owner drops request mid-packet: bubble, no re-arbitration
      step(mk(1, 4'b0000, 16'h1111, 0, 0, 4'b0000, 0, 0), "bubble_rst");
      step(mk(0, 4'b0011, 16'h1111, 1, 0, 4'b0001, 1, 0), "bubble_first");
      step(mk(0, 4'b0010, 16'h1111, 1, 0, 4'b0001, 0, 0), "bubble_hold0");
      step(mk(0, 4'b0010, 16'h1111, 1, 1, 4'b0001, 0, 0), "bubble_hold1");
      step(mk(0, 4'b0011, 16'h1111, 1, 1, 4'b0001, 1, 0), "bubble_last");
      step(mk(0, 4'b0011, 16'h1111, 0, 0, 4'b0010, 1, 1), "bubble_next");
`endif

      // randomized traffic against the reference model
      for (int c = 0; c < 800; c++) begin
         rr = ($urandom % 64) == 0;
         rq = W'($urandom);
         rw = '0;
         for (int k = 0; k < int'(W); k++)
            rw[k*WEIGHT_W +: WEIGHT_W] = ($urandom % 8 == 0) ? WEIGHT_W'($urandom)
                                                             : WEIGHT_W'($urandom % 4);
         ra = ($urandom % 4) != 0;
         rl = ($urandom % 3) == 0;
         model_out(rr, rq, eg, ev, ee);
         step(mk(rr, rq, rw, ra, rl, eg, ev, ee), $sformatf("random[%0d]", c));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
